// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between fetch_unit (master) and instruction memory (slave).
interface fetch_unit_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_done;

  modport master (output mem_rd, mem_addr, input  mem_data, mem_done);
  modport slave  (input  mem_rd, mem_addr, output mem_data, mem_done);
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with redirect, stall, drain and halt handling.
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect traps to HALT with err).
module fetch_unit (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [15:0]         redirect_pc,
  input  logic                stall,
  input  logic                halt,
  fetch_unit_if.master        mem,
  output logic [15:0]         instr,
  output logic [15:0]         PC_old,
  output logic [15:0]         PC_inc,
  output logic                instr_valid,
  output logic                halted,
  output logic                err
);

  typedef enum logic [1:0] {FETCH, VALID, DRAIN, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_old_q, pc_old_d;
  logic [15:0] pc_inc_q, pc_inc_d;
  logic        err_q, err_d;

  logic [15:0] pc_plus2;
  logic [15:0] redir_tgt;
  logic        redir_bad;
  logic        redir_load;
  logic        redir_trap;

  assign pc_plus2  = pc_q + 16'd2;
  assign redir_tgt = {redirect_pc[15:1], 1'b0};

`ifdef FETCH_ALIGN_CHK_EN
  assign redir_bad = redirect_pc[0];
`else
  logic unused_redirect_pc0;
  assign unused_redirect_pc0 = redirect_pc[0];
  assign redir_bad           = 1'b0;
`endif

  assign redir_load = redirect & ~redir_bad;
  assign redir_trap = redirect &  redir_bad;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_old_d = pc_old_q;
    pc_inc_d = pc_inc_q;
    err_d    = err_q;

    unique case (state_q)
      FETCH: begin
        if (redir_trap) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else if (redir_load) begin
          // In-flight read must still complete before a new request may issue
          pc_d    = redir_tgt;
          state_d = mem.mem_done ? FETCH : DRAIN;
        end else if (mem.mem_done) begin
          instr_d  = mem.mem_data;
          pc_old_d = pc_q;
          pc_inc_d = pc_plus2;
          pc_d     = pc_plus2;
          state_d  = VALID;
        end
      end
      VALID: begin
        // halt only counts on a consuming edge, and then beats redirect
        if (!stall && halt) begin
          state_d = HALT;
        end else if (redir_trap) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else if (redir_load) begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redir_trap) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          if (redir_load) pc_d = redir_tgt;
          if (mem.mem_done) state_d = FETCH;
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      instr_q  <= '0;
      pc_old_q <= '0;
      pc_inc_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_old_q <= pc_old_d;
      pc_inc_q <= pc_inc_d;
      err_q    <= err_d;
    end
  end

  assign mem.mem_rd   = (state_q == FETCH);
  assign mem.mem_addr = pc_q;
  assign instr        = instr_q;
  assign PC_old       = pc_old_q;
  assign PC_inc       = pc_inc_q;
  assign instr_valid  = (state_q == VALID);
  assign halted       = (state_q == HALT);
  assign err          = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; instruction memory is driven step by step.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic [15:0] instr, PC_old, PC_inc;
  logic        instr_valid, halted, err;

  int unsigned nchecks = 0;
  int unsigned nerr    = 0;
  logic [15:0] exp_a;

  fetch_unit_if mem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .halt        (halt),
    .mem         (mem_bus.master),
    .instr       (instr),
    .PC_old      (PC_old),
    .PC_inc      (PC_inc),
    .instr_valid (instr_valid),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Request seen, mem_done one cycle later, instruction valid on the following edge.
  task automatic do_fetch(input logic [15:0] data, input logic [15:0] addr);
    chk("fetch_rd", {15'd0, mem_bus.mem_rd}, 16'd1);
    chk("fetch_addr", mem_bus.mem_addr, addr);
    tick();
    mem_bus.mem_done = 1'b1;
    mem_bus.mem_data = data;
    tick();
    mem_bus.mem_done = 1'b0;
    mem_bus.mem_data = 16'hxxxx;
    chk("fetch_valid", {15'd0, instr_valid}, 16'd1);
    chk("fetch_rd_low", {15'd0, mem_bus.mem_rd}, 16'd0);
    chk("fetch_instr", instr, data);
    chk("fetch_pc_old", PC_old, addr);
    chk("fetch_pc_inc", PC_inc, addr + 16'd2);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; halt = 1'b0;
    mem_bus.mem_done = 1'b0; mem_bus.mem_data = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_rd", {15'd0, mem_bus.mem_rd}, 16'd1);
    chk("rst_addr", mem_bus.mem_addr, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc_old", PC_old, 16'h0000);
    chk("rst_pc_inc", PC_inc, 16'h0000);

    // Sequential fetches 0, 2, 4
    do_fetch(16'h1111, 16'h0000);
    tick();
    do_fetch(16'h2222, 16'h0002);
    tick();
    do_fetch(16'h1234, 16'h0004);

    // Stall holds the VALID instruction
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", instr, 16'h1234);
      chk("stall_pc_old", PC_old, 16'h0004);
      chk("stall_rd", {15'd0, mem_bus.mem_rd}, 16'd0);
      chk("stall_valid", {15'd0, instr_valid}, 16'd1);
    end
    stall = 1'b0;
    tick();
    chk("post_stall_addr", mem_bus.mem_addr, 16'h0006);

    // Redirect mid-fetch: drain, then refetch at 0x0040
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("drain_rd", {15'd0, mem_bus.mem_rd}, 16'd0);
    chk("drain_addr", mem_bus.mem_addr, 16'h0040);
    chk("drain_valid", {15'd0, instr_valid}, 16'd0);
    tick();
    chk("drain_rd_hold", {15'd0, mem_bus.mem_rd}, 16'd0);
    tick();
    mem_bus.mem_done = 1'b1; mem_bus.mem_data = 16'hDEAD;
    tick();
    mem_bus.mem_done = 1'b0;
    chk("drop_instr", instr, 16'h1234);
    chk("drop_valid", {15'd0, instr_valid}, 16'd0);
    do_fetch(16'hBEEF, 16'h0040);
    tick();

    // Redirect coincident with mem_done
    mem_bus.mem_done = 1'b1; mem_bus.mem_data = 16'h5555;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    mem_bus.mem_done = 1'b0; redirect = 1'b0;
    chk("coinc_valid", {15'd0, instr_valid}, 16'd0);
    chk("coinc_instr", instr, 16'hBEEF);

    // Wraparound at 0xFFFE
    do_fetch(16'h7777, 16'hFFFE);
    chk("wrap_pc_inc", PC_inc, 16'h0000);
    tick();
    chk("wrap_addr", mem_bus.mem_addr, 16'h0000);
    chk("wrap_err", {15'd0, err}, 16'd0);

    // Redirect beats stall in VALID; halt ignored because nothing was consumed
    do_fetch(16'h3333, 16'h0000);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100; halt = 1'b1;
    tick();
    stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    chk("rv_valid", {15'd0, instr_valid}, 16'd0);
    chk("rv_rd", {15'd0, mem_bus.mem_rd}, 16'd1);
    chk("rv_addr", mem_bus.mem_addr, 16'h0100);
    chk("rv_halted", {15'd0, halted}, 16'd0);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    chk("align_err", {15'd0, err}, 16'd1);
    chk("align_halted", {15'd0, halted}, 16'd1);
    chk("align_rd", {15'd0, mem_bus.mem_rd}, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("align_rst_err", {15'd0, err}, 16'd0);
    exp_a = 16'h0000;
`else
    chk("align_addr", mem_bus.mem_addr, 16'h0040);
    chk("align_err", {15'd0, err}, 16'd0);
    chk("align_rd", {15'd0, mem_bus.mem_rd}, 16'd0);
    mem_bus.mem_done = 1'b1;
    tick();
    mem_bus.mem_done = 1'b0;
    exp_a = 16'h0040;
`endif

    // Halt wins over redirect on a consuming edge
    do_fetch(16'h4444, exp_a);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    halt = 1'b0; redirect = 1'b0;
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_rd", {15'd0, mem_bus.mem_rd}, 16'd0);
    chk("halt_valid", {15'd0, instr_valid}, 16'd0);
    chk("halt_addr", mem_bus.mem_addr, exp_a + 16'd2);
    redirect = 1'b1; redirect_pc = 16'h0300; mem_bus.mem_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stay", {15'd0, halted}, 16'd1);
      chk("halt_stay_rd", {15'd0, mem_bus.mem_rd}, 16'd0);
      chk("halt_stay_addr", mem_bus.mem_addr, exp_a + 16'd2);
    end
    redirect = 1'b0; mem_bus.mem_done = 1'b0;

    // Reset leaves HALT and restarts at 0x0000
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rerst_halted", {15'd0, halted}, 16'd0);
    chk("rerst_instr", instr, 16'h0000);
    chk("rerst_err", {15'd0, err}, 16'd0);
    do_fetch(16'h9999, 16'h0000);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
